// File: rtl/reg_dump_pkg.sv
// -----------------------------------------------------------------------------
// reg_dump_pkg
// Shared definitions for the register-file debug read-out sequencer.
//   dump_state_t : FSM state encoding (IDLE, READ, SEND, DONE)
//   PW_DEFAULT   : default register address width
//   NUM_REGS     : number of registers dumped at the default address width
// -----------------------------------------------------------------------------
package reg_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

  localparam int PW_DEFAULT = 3;
  localparam int NUM_REGS   = 2 ** PW_DEFAULT;

endpackage : reg_dump_pkg

// File: rtl/reg_dump.sv
// -----------------------------------------------------------------------------
// reg_dump
// Debug read-out sequencer for the CPU register file. A start pulse walks every
// register address 0 .. 2**pw-1 through one combinational read port and streams
// each value, tagged with its address, over a valid/ready handshake.
//
// Parameters
//   pw : register address width (2**pw registers are dumped)
//   dw : register data width
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_start      one-cycle dump request, honoured only in IDLE
//   i_abort      cancels a running dump, highest priority
//   o_rd_addr    registered register-file read address
//   i_rd_data    combinational register-file read data for o_rd_addr
//   o_out_data   captured register value
//   o_out_addr   address of o_out_data
//   o_out_valid  payload valid
//   i_out_ready  consumer accepts the current beat
//   o_out_last   current beat is the last register
//   o_busy       high in READ and SEND
//   o_done       one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int pw = 3,
  parameter int dw = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_abort,
  output logic [pw-1:0] o_rd_addr,
  input  logic [dw-1:0] i_rd_data,
  output logic [dw-1:0] o_out_data,
  output logic [pw-1:0] o_out_addr,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic          o_out_last,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [pw-1:0] LAST_IDX = '1;

  dump_state_t   r_state;
  dump_state_t   w_state_next;

  logic [pw-1:0] r_idx,       w_idx_next;
  logic [pw-1:0] r_rd_addr,   w_rd_addr_next;
  logic [dw-1:0] r_out_data,  w_out_data_next;
  logic [pw-1:0] r_out_addr,  w_out_addr_next;
  logic          r_out_valid, w_out_valid_next;
  logic          r_out_last,  w_out_last_next;
  logic          r_busy,      w_busy_next;
  logic          r_done,      w_done_next;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath / output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_idx       <= '0;
      r_rd_addr   <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_idx       <= w_idx_next;
      r_rd_addr   <= w_rd_addr_next;
      r_out_data  <= w_out_data_next;
      r_out_addr  <= w_out_addr_next;
      r_out_valid <= w_out_valid_next;
      r_out_last  <= w_out_last_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
    end
  end

  // Next-state and next-output logic. All outputs are registered, so each
  // transition sets up the values the following state must present.
  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_rd_addr_next   = r_rd_addr;
    w_out_data_next  = r_out_data;
    w_out_addr_next  = r_out_addr;
    w_out_valid_next = r_out_valid;
    w_out_last_next  = r_out_last;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next   = READ;
          w_idx_next     = '0;
          w_rd_addr_next = '0;
          w_busy_next    = 1'b1;
        end
      end

      READ: begin
        // o_rd_addr already equals r_idx here, so i_rd_data is this register.
        w_out_data_next  = i_rd_data;
        w_out_addr_next  = r_idx;
        w_out_valid_next = 1'b1;
        w_out_last_next  = (r_idx == LAST_IDX);
        w_state_next     = SEND;
      end

      SEND: begin
        if (r_out_valid && i_out_ready) begin
          w_out_valid_next = 1'b0;
          w_out_last_next  = 1'b0;
          if (r_out_last) begin
            w_state_next   = DONE;
            w_busy_next    = 1'b0;
            w_done_next    = 1'b1;
            w_idx_next     = '0;
            w_rd_addr_next = '0;
          end else begin
            w_state_next   = READ;
            w_idx_next     = r_idx + pw'(1);
            w_rd_addr_next = r_idx + pw'(1);
          end
        end
      end

      DONE: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Abort overrides everything. In IDLE these registers are already at
    // their idle values, so applying it there simply suppresses a same-cycle
    // start.
    if (i_abort) begin
      w_state_next     = IDLE;
      w_idx_next       = '0;
      w_rd_addr_next   = '0;
      w_out_valid_next = 1'b0;
      w_out_last_next  = 1'b0;
      w_busy_next      = 1'b0;
      w_done_next      = 1'b0;
    end
  end

  assign o_rd_addr   = r_rd_addr;
  assign o_out_data  = r_out_data;
  assign o_out_addr  = r_out_addr;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule : reg_dump

// File: tb/tb_reg_dump.sv
// -----------------------------------------------------------------------------
// tb_reg_dump
// Directed self-checking bench for reg_dump with a behavioural register file.
// -----------------------------------------------------------------------------
module tb_reg_dump;
  import reg_dump_pkg::*;

  localparam int PW = 3;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [PW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] regfile [NUM_REGS];
  logic [DW-1:0] exp_data [NUM_REGS];

  int n_cmp;
  int n_bad;
  int done_cnt;

  reg_dump #(.pw(PW), .dw(DW)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_abort     (abort),
    .o_rd_addr   (rd_addr),
    .i_rd_data   (rd_data),
    .o_out_data  (out_data),
    .o_out_addr  (out_addr),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_done      (done)
  );

  assign rd_data = regfile[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int mode);
    for (int i = 0; i < NUM_REGS; i++) begin
      case (mode)
        0:       regfile[i] = 8'h10 + 8'(i);
        1:       regfile[i] = 8'h00;
        default: regfile[i] = 8'hFF;
      endcase
      exp_data[i] = regfile[i];
    end
  endtask

  // Full dump starting from a negedge in IDLE. stall_beat holds out_ready low
  // for 5 cycles on that beat; restart pulses start during beat 4 and in DONE.
  task automatic run_dump(input string name, input int stall_beat, input bit restart);
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, " start_busy"}, 32'(busy), 32'd1);
    chk({name, " start_rdaddr"}, 32'(rd_addr), 32'd0);
    chk({name, " start_valid"}, 32'(out_valid), 32'd0);
    for (int i = 0; i < NUM_REGS; i++) begin
      @(negedge clk);
      chk($sformatf("%s b%0d valid", name, i), 32'(out_valid), 32'd1);
      chk($sformatf("%s b%0d addr", name, i), 32'(out_addr), 32'(i));
      chk($sformatf("%s b%0d data", name, i), 32'(out_data), 32'(exp_data[i]));
      chk($sformatf("%s b%0d last", name, i), 32'(out_last), 32'(i == NUM_REGS - 1));
      if (i == stall_beat) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("%s stall%0d valid", name, k), 32'(out_valid), 32'd1);
          chk($sformatf("%s stall%0d addr", name, k), 32'(out_addr), 32'(i));
          chk($sformatf("%s stall%0d data", name, k), 32'(out_data), 32'(exp_data[i]));
        end
        out_ready = 1'b1;
      end
      if (restart && i == 4) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (i < NUM_REGS - 1) begin
        chk($sformatf("%s r%0d valid", name, i + 1), 32'(out_valid), 32'd0);
        chk($sformatf("%s r%0d rdaddr", name, i + 1), 32'(rd_addr), 32'(i + 1));
        chk($sformatf("%s r%0d busy", name, i + 1), 32'(busy), 32'd1);
        chk($sformatf("%s r%0d done", name, i + 1), 32'(done), 32'd0);
      end else begin
        chk({name, " done_pulse"}, 32'(done), 32'd1);
        chk({name, " done_busy"}, 32'(busy), 32'd0);
        chk({name, " done_valid"}, 32'(out_valid), 32'd0);
        chk({name, " done_rdaddr"}, 32'(rd_addr), 32'd0);
        if (restart) start = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk({name, " post_done"}, 32'(done), 32'd0);
    chk({name, " post_busy"}, 32'(busy), 32'd0);
    chk({name, " done_count"}, 32'(done_cnt), 32'(d0 + 1));
    if (restart) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk($sformatf("%s idle%0d busy", name, k), 32'(busy), 32'd0);
        chk($sformatf("%s idle%0d valid", name, k), 32'(out_valid), 32'd0);
      end
      chk({name, " single_done"}, 32'(done_cnt), 32'(d0 + 1));
    end
  endtask

  initial begin
    int d0;
    n_cmp     = 0;
    n_bad     = 0;
    done_cnt  = 0;
    reset     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    load(0);

    // Reset state (asynchronous, before any clock edge)
    #1 reset = 1'b1;
    #2;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst last", 32'(out_last), 32'd0);
    chk("rst rdaddr", 32'(rd_addr), 32'd0);
    chk("rst data", 32'(out_data), 32'd0);
    chk("rst addr", 32'(out_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic dump
    run_dump("basic", -1, 1'b0);

    // Backpressure on beat 3
    run_dump("bp", 3, 1'b0);

    // Start re-pulsed during beat 4 and in the DONE cycle
    run_dump("restart", -1, 1'b1);

    // Abort and start in the same IDLE cycle: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abst busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("abst valid", 32'(out_valid), 32'd0);

    // Abort during SEND of beat 5
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      @(negedge clk);
    end
    @(negedge clk);
    chk("abort pre addr", 32'(out_addr), 32'd5);
    chk("abort pre valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort valid", 32'(out_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort rdaddr", 32'(rd_addr), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort last", 32'(out_last), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort idle%0d busy", k), 32'(busy), 32'd0);
    end
    chk("abort no_done", 32'(done_cnt), 32'(d0));
    run_dump("after_abort", -1, 1'b0);

    // Asynchronous reset during beat 2
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      @(negedge clk);
    end
    @(negedge clk);
    chk("mrst pre addr", 32'(out_addr), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("mrst busy", 32'(busy), 32'd0);
    chk("mrst valid", 32'(out_valid), 32'd0);
    chk("mrst done", 32'(done), 32'd0);
    chk("mrst last", 32'(out_last), 32'd0);
    chk("mrst rdaddr", 32'(rd_addr), 32'd0);
    chk("mrst data", 32'(out_data), 32'd0);
    chk("mrst addr", 32'(out_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst idle busy", 32'(busy), 32'd0);

    // All-zero and all-ones payloads
    load(1);
    run_dump("zeros", -1, 1'b0);
    load(2);
    run_dump("ones", -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_reg_dump
